rng_share_arbiter: RTL and testbench

Shares one 20-bit Fibonacci LFSR random source among `N_REQ` stochastic-bitstream requesters, handing out one full 20-bit random word per cycle to a single requester under round-robin arbitration. It owns the LFSR state, sequences seeding and a post-seed warm-up interval, and blocks grants while the generator is not yet decorrelated. It sits between the per-operand stochastic number generators and the shared randomness, replacing one LFSR per consumer.

---
 rtl/rng_pkg.sv | 22 ++
 rtl/rr_pick.sv | 39 +++
 rtl/rng_share_arbiter.sv | 132 +++++++++++++
 tb/tb_rng_share_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the random-source arbiter: LFSR width and taps,
// warm-up counter width, FSM state type and the LFSR step function.
package rng_pkg;

  localparam int RNG_W  = 20;
  localparam int TAP_HI = 19;
  localparam int TAP_LO = 16;

  // Wide enough for warm-up intervals of 0..1023 steps.
  localparam int WCNT_W = 10;

  typedef enum logic {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } rng_state_t;

  // Fibonacci LFSR x^20 + x^17 + 1, shifting towards the MSB.
  function automatic logic [RNG_W-1:0] lfsr_next(input logic [RNG_W-1:0] s);
    return {s[RNG_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the most recently served requester
//   valid - at least one request is present
//   pick  - one-hot winner (zero when no request)
//   idx   - index of the winner (holds last when no request)
// The winner is the first set request strictly after last, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set request after
  // last is the one left standing when the loop ends.
  always_comb begin
    valid = |req;
    pick  = '0;
    idx   = last;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule

// File: rtl/rng_share_arbiter.sv
// Shares one 20-bit Fibonacci LFSR among N_REQ requesters, handing one full
// random word per cycle to a single round-robin winner. Grants are blocked
// during a warm-up interval after reset or after any seed load.
// Ports:
//   CLK       - clock, all state updates on the rising edge
//   nRST      - synchronous active-low reset
//   req       - level request per requester, held until granted
//   seed_load - one-cycle pulse, loads seed_in into the LFSR
//   seed_in   - new seed (zero is rejected and SEED is used instead)
//   grant     - registered one-hot grant
//   r         - random word, valid while any grant bit is high
//   busy      - high while warming up
//   seed_err  - one-cycle pulse after a zero seed was rejected
//
// state  | meaning
// WARMUP | LFSR stepping after reset/seed load, no grants issued
// SERVE  | one grant per cycle to the round-robin winner
module rng_share_arbiter
  import rng_pkg::*;
#(
  parameter int               N_REQ         = 4,
  parameter logic [RNG_W-1:0] SEED          = 20'h5EED1,
  parameter int               WARMUP_CYCLES = 20
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [N_REQ-1:0]   req,
  input  logic               seed_load,
  input  logic [RNG_W-1:0]   seed_in,
  output logic [N_REQ-1:0]   grant,
  output logic [RNG_W-1:0]   r,
  output logic               busy,
  output logic               seed_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [WCNT_W-1:0] WCNT_INIT  = WCNT_W'(WARMUP_CYCLES);
  // With no warm-up interval the arbiter serves straight out of reset/load.
  localparam rng_state_t        STATE_INIT = (WARMUP_CYCLES == 0) ? SERVE : WARMUP;
  // Starting from the top index makes requester 0 the first winner.
  localparam logic [IW-1:0]     LAST_INIT  = IW'(N_REQ - 1);

  rng_state_t        state, state_n;
  logic [RNG_W-1:0]  s, s_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic [IW-1:0]     last, last_n;
  logic [N_REQ-1:0]  grant_n;
  logic [RNG_W-1:0]  r_n;
  logic              busy_n;
  logic              seed_err_n;

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .pick  (pick_oh),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= STATE_INIT;
      s        <= SEED;
      wcnt     <= WCNT_INIT;
      last     <= LAST_INIT;
      grant    <= '0;
      r        <= '0;
      busy     <= (STATE_INIT == WARMUP);
      seed_err <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      wcnt     <= wcnt_n;
      last     <= last_n;
      grant    <= grant_n;
      r        <= r_n;
      busy     <= busy_n;
      seed_err <= seed_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    s_n        = lfsr_next(s);  // free-running in every state
    wcnt_n     = wcnt;
    last_n     = last;
    grant_n    = '0;
    r_n        = r;
    seed_err_n = 1'b0;

    if (seed_load) begin
      // A load wins over any same-cycle request; the request stays pending.
      if (seed_in == '0) begin
        s_n        = SEED;
        seed_err_n = 1'b1;
      end else begin
        s_n = seed_in;
      end
      wcnt_n  = WCNT_INIT;
      state_n = STATE_INIT;
    end else begin
      case (state)
        WARMUP: begin
          if (wcnt <= WCNT_W'(1)) begin
            state_n = SERVE;
          end else begin
            wcnt_n = wcnt - WCNT_W'(1);
          end
        end
        SERVE: begin
          if (pick_valid) begin
            grant_n = pick_oh;
            r_n     = s;  // word handed out is the pre-step value
            last_n  = pick_idx;
          end
        end
        default: state_n = STATE_INIT;
      endcase
    end

    busy_n = (state_n == WARMUP);
  end

endmodule

// File: tb/tb_rng_share_arbiter.sv
module tb_rng_share_arbiter;

  localparam int          N   = 4;
  localparam int          W   = 4;
  localparam logic [19:0] SDV = 20'h00001;

  logic          CLK;
  logic          nRST;
  logic [N-1:0]  req;
  logic          seed_load;
  logic [19:0]   seed_in;
  logic [N-1:0]  grant;
  logic [19:0]   r;
  logic          busy;
  logic          seed_err;

  rng_share_arbiter #(
    .N_REQ         (N),
    .SEED          (SDV),
    .WARMUP_CYCLES (W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req       (req),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .grant     (grant),
    .r         (r),
    .busy      (busy),
    .seed_err  (seed_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] g;
    logic [19:0]  r;
  } gnt_t;

  typedef struct {
    logic busy;
    logic err;
  } st_t;

  gnt_t gq[$];
  st_t  sq[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Reference model: LFSR word, warm-up edges remaining, last winner.
  logic [19:0] m_s;
  int          m_wrem;
  int          m_last;
  int          m_gidx;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [19:0] step(input logic [19:0] v);
    return {v[18:0], v[19] ^ v[16]};
  endfunction

  task automatic model_step(input logic rb, input logic [N-1:0] rq,
                            input logic ld, input logic [19:0] si);
    logic err;
    int   j;
    err    = 1'b0;
    m_gidx = -1;
    if (!rb) begin
      m_s    = SDV;
      m_wrem = W;
      m_last = N - 1;
    end else if (ld) begin
      if (si == 20'h0) begin
        m_s = SDV;
        err = 1'b1;
      end else begin
        m_s = si;
      end
      m_wrem = W;
    end else if (m_wrem > 0) begin
      m_wrem--;
      m_s = step(m_s);
    end else begin
      if (rq != '0) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (rq[2'(j)]) begin
            m_gidx = j;
            break;
          end
        end
        gq.push_back('{g: N'(1) << m_gidx, r: m_s});
        m_last = m_gidx;
      end
      m_s = step(m_s);
    end
    sq.push_back('{busy: (m_wrem > 0), err: err});
  endtask

  task automatic cycle(input logic rb, input logic [N-1:0] rq,
                       input logic ld, input logic [19:0] si);
    nRST      = rb;
    req       = rq;
    seed_load = ld;
    seed_in   = si;
    model_step(rb, rq, ld, si);
    mon_en    = 1'b1;
    @(negedge CLK);
  endtask

  // Monitor: status every cycle, grant transactions whenever the DUT grants.
  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      if (sq.size() > 0) begin
        st_t e;
        e = sq.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("seed_err", 32'(seed_err), 32'(e.err));
      end
      if (grant !== '0) begin
        if (gq.size() == 0) begin
          chk("spurious_grant", 32'(grant), 32'h0);
        end else begin
          gnt_t g;
          g = gq.pop_front();
          chk("grant", 32'(grant), 32'(g.g));
          chk("r", 32'(r), 32'(g.r));
        end
      end else if (gq.size() > 0) begin
        gnt_t g;
        g = gq.pop_front();
        chk("missing_grant", 32'(grant), 32'(g.g));
      end
    end
  end

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] exp_seq [4];
    nRST = 1'b0; req = '0; seed_load = 1'b0; seed_in = '0;
    @(negedge CLK);

    // Reset state.
    cycle(1'b0, '0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, '0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_r", 32'(r), 32'h0);

    // Warm-up of W edges, then first grant to requester 0 with r = 0x10.
    for (int k = 1; k <= W; k++) begin
      cycle(1'b1, 4'b0001, 1'b0, '0);
      chk("wu_busy", 32'(busy), 32'(k < W));
      chk("wu_grant", 32'(grant), 32'h0);
    end
    cycle(1'b1, 4'b0001, 1'b0, '0);
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_r", 32'(r), 32'h00010);

    // All requesting: strict rotation.
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 4'b1111, 1'b0, '0);
      chk("rotate", 32'(grant), 32'(exp_seq[k]));
    end
    cycle(1'b1, 4'b1111, 1'b0, '0);

    // Zero seed load beats a same-cycle request.
    cycle(1'b1, 4'b0100, 1'b1, 20'h0);
    chk("zload_grant", 32'(grant), 32'h0);
    chk("zload_err", 32'(seed_err), 32'h1);
    chk("zload_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= W; k++) begin
      cycle(1'b1, 4'b0100, 1'b0, '0);
      chk("zload_wu_busy", 32'(busy), 32'(k < W));
      if (k == 1) chk("zload_err_drop", 32'(seed_err), 32'h0);
    end
    cycle(1'b1, 4'b0100, 1'b0, '0);
    chk("zload_grant2", 32'(grant), 32'b0100);
    chk("zload_r", 32'(r), 32'h00010);

    // Load in the middle of warm-up restarts the count.
    cycle(1'b1, '0, 1'b1, 20'h10000);
    cycle(1'b1, '0, 1'b0, '0);
    cycle(1'b1, '0, 1'b0, '0);
    cycle(1'b1, 4'b0001, 1'b1, 20'h10000);
    for (int k = 1; k <= W; k++) begin
      cycle(1'b1, 4'b0001, 1'b0, '0);
      chk("reload_busy", 32'(busy), 32'(k < W));
    end
    cycle(1'b1, 4'b0001, 1'b0, '0);
    chk("reload_grant", 32'(grant), 32'h1);
    chk("reload_r", 32'(r), 32'h00009);

    // Fairness between 3 and 0, then a lone requester every cycle.
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'b1001, 1'b0, '0);
      chk("fair", 32'(grant), 32'(exp_seq[k]));
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'b0010, 1'b0, '0);
      chk("lone", 32'(grant), 32'b0010);
    end

    // Randomised traffic with occasional loads and resets.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      logic          rb, ld;
      logic [19:0]   si;
      rb = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 59) == 0);
      si = ($urandom_range(0, 3) == 0) ? 20'h0 : 20'($urandom);
      cycle(rb, pend, ld, si);
      if (m_gidx >= 0 && $urandom_range(0, 1) == 1) pend[2'(m_gidx)] = 1'b0;
      pend = pend | (N'($urandom) & N'($urandom));
    end

    cycle(1'b1, '0, 1'b0, '0);
    @(negedge CLK);
    chk("queue_drained", 32'(gq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
